// File: rtl/cache_miss_unit.sv
// cache_miss_unit: one-at-a-time miss servicing with line refill, store merge, uncached word access and a concurrent victim writeback.
module cache_miss_unit #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_req,
  output logic                     req_rdy,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     miss_uncached,
  input  logic                     miss_wr,
  input  logic [31:0]              miss_wdata,
  input  logic [3:0]               miss_wstrb,
  input  logic                     victim_valid,
  input  logic [ADDR_W-1:0]        victim_addr,
  input  logic [32*LINE_WORDS-1:0] victim_data,
  output logic                     rd_req,
  output logic [2:0]               rd_type,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_rdy,
  input  logic                     ret_valid,
  input  logic                     ret_last,
  input  logic [31:0]              ret_data,
  output logic                     wr_req,
  output logic [2:0]               wr_type,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [3:0]               wr_wstrb,
  output logic [32*LINE_WORDS-1:0] wr_data,
  input  logic                     wr_rdy,
  output logic                     refill_done,
  output logic [32*LINE_WORDS-1:0] refill_data,
  output logic                     refill_err
);
  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam int OFF = $clog2(LINE_WORDS) + 2;
  localparam int BW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_W-1:0] LMASK = ~ADDR_W'((1 << OFF) - 1);
  localparam logic [ADDR_W-1:0] WMASK = ~ADDR_W'(3);
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);
  localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_RECV = 3'd2, UC_WR = 3'd3, DONE = 3'd4;

  logic [2:0]           state;
  logic                 wb_valid, unc_q, wr_q, err, acc, fin, uc;
  logic [ADDR_W-1:0]    wb_addr, addr_q;
  logic [LINE_BITS-1:0] wb_data, line_q, nxt, mrg;
  logic [31:0]          wdata_q;
  logic [3:0]           wstrb_q;
  logic [BW-1:0]        beat, widx;

  // Any request that could read a line still waiting in the writeback buffer must stall.
  assign req_rdy = rst & (state == IDLE) &
                   !(wb_valid & (victim_valid | miss_uncached | ((miss_addr & LMASK) == wb_addr)));
  assign acc  = miss_req & req_rdy;
  assign fin  = beat == (unc_q ? '0 : LAST);
  assign widx = LINE_WORDS == 1 ? '0 : BW'(addr_q[ADDR_W-1:2]);
  assign uc   = state == UC_WR;

  assign rd_req      = state == RD_REQ;
  assign rd_type     = !rd_req ? 3'b000 : unc_q ? 3'b010 : 3'b100;
  assign rd_addr     = unc_q ? addr_q & WMASK : addr_q & LMASK;
  assign wr_req      = wb_valid | uc;
  assign wr_type     = uc ? 3'b010 : wb_valid ? 3'b100 : 3'b000;
  assign wr_addr     = uc ? addr_q & WMASK : wb_addr;
  assign wr_wstrb    = uc ? wstrb_q : {4{wb_valid}};
  assign wr_data     = uc ? LINE_BITS'(wdata_q) : wb_data;
  assign refill_done = state == DONE;
  assign refill_err  = refill_done & err;

  always_comb begin
    nxt = line_q;
    if (state == RD_RECV && ret_valid) nxt[{beat, 5'b0} +: 32] = ret_data;
    mrg = nxt;
    for (int b = 0; b < 4; b++)
      if (wr_q & !unc_q & wstrb_q[b]) mrg[{widx, 5'b0} + b*8 +: 8] = wdata_q[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      addr_q      <= '0;
      unc_q       <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      beat        <= '0;
      err         <= 1'b0;
      line_q      <= '0;
      refill_data <= '0;
    end else begin
      if (wb_valid & wr_rdy) wb_valid <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          addr_q  <= miss_addr;
          unc_q   <= miss_uncached;
          wr_q    <= miss_wr;
          wdata_q <= miss_wdata;
          wstrb_q <= miss_wstrb;
          beat    <= '0;
          line_q  <= '0;
          state   <= (miss_uncached & miss_wr) ? UC_WR : RD_REQ;
          if (victim_valid & !miss_uncached) begin
            wb_valid <= 1'b1;
            wb_addr  <= victim_addr & LMASK;
            wb_data  <= victim_data;
          end
        end
        RD_REQ: if (rd_rdy) state <= RD_RECV;
        RD_RECV: if (ret_valid) begin
          line_q <= nxt;
          beat   <= beat + 1'b1;
          if (fin | ret_last) begin
            state       <= DONE;
            err         <= !fin;
            refill_data <= mrg;
          end
        end
        UC_WR: if (wr_rdy) state <= DONE;
        DONE: begin
          state <= IDLE;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
